scan_master: RTL
================

# scan_master

Digital initiator for the two-phase scan chain on the FADC test chip. It drives `scan_phi`, `scan_phi_bar`, `scan_data_in`, `scan_load_chip` and `scan_load_chain`, and captures `scan_data_out`. It is the host side of the `ex_scan` protocol. It sits in the FPGA/test-board logic facing the chip's scan pads, and converts a parallel write/read command into bit-serial, non-overlapping phase-clock sequences.

## Interface
Parameters:
- `CHAIN_LEN`, 64: scan chain length in bits (≥2).
- `PHASE_CYC`, 4: `clk` cycles per phase pulse and per gap (≥2; elaboration error otherwise).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE and not in reset.
- `cmd_capture`  in  1  pulse `scan_load_chain` before shifting.
- `cmd_update`  in  1  pulse `scan_load_chip` after shifting.
- `cmd_wdata`  in  CHAIN_LEN  data shifted into the chain, MSB first.
- `rsp_valid`  out  1  one-cycle pulse at command completion.
- `rsp_data`  out  CHAIN_LEN  bits shifted out. The first bit out lands in the MSB. Held until the next accept.
- `scan_reset`  out  1  `reset` registered once.
- `scan_phi`, `scan_phi_bar`, `scan_load_chip`, `scan_load_chain`  out  1 each  phase/load strobes, registered.
- `scan_data_in`  out  1  serial data to chip, registered.
- `scan_data_out`  in  1  serial data from chip, asynchronous to `clk`.

## Operation
- Accept when `cmd_valid && cmd_ready`. On accept:
  - `sr <= cmd_wdata`.
  - Latch `cmd_capture` and `cmd_update`.
  - Bit counter `<= CHAIN_LEN-1`.
- State machine: IDLE → (CAP_HI → CAP_GAP if capture) → PHI_HI → PHI_GAP → PHB_HI → PHB_GAP → (repeat per bit) → (UPD_HI → UPD_GAP if update) → DONE → IDLE.
- Each *_HI and *_GAP state lasts exactly `PHASE_CYC` cycles.
- Strobes by state; every strobe is low in all other states, so phases never overlap:
  - CAP_HI: `scan_load_chain=1` and `scan_phi_bar=1`.
  - PHI_HI: `scan_phi=1`.
  - PHB_HI: `scan_phi_bar=1`.
  - UPD_HI: `scan_load_chip=1`.
- `scan_data_in = sr[CHAIN_LEN-1]`. It is valid from entry to PHI_HI through the end of PHB_GAP for that bit.
- `scan_data_out` passes through a 2-flop synchronizer. The sync output is sampled on the last cycle of PHI_GAP.
- On the last cycle of PHB_GAP, `sr <= {sr[CHAIN_LEN-2:0], sample}` and the bit counter decrements. After the bit at counter 0, exit the shift loop.
- DONE (1 cycle): `rsp_data <= sr`, `rsp_valid=1`.
- `cmd_valid` outside IDLE is ignored; no queueing.

## Timing
- Reset values:
  - All scan strobes and `scan_data_in` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `cmd_ready` = 0 during reset.
  - State = IDLE.
  - `scan_reset` = 1 one cycle after `reset` rises, and 0 one cycle after it falls.
- Accept at edge T; first strobe-state cycle is T+1.
- Duration D = (capture ? 2P : 0) + 4P·CHAIN_LEN + (update ? 2P : 0), where P = `PHASE_CYC`.
- `rsp_valid` is high in cycle T+1+D. `cmd_ready` returns in cycle T+2+D, so back-to-back commands are spaced D+2 cycles apart.
- Reset mid-operation: at the next edge all strobes are low and the state is IDLE. No `rsp_valid`, and `rsp_data` is cleared.
- Read-only use: `cmd_wdata` still shifts in. To preserve chip state without an update, omit `cmd_update`.

## Structure
- `scan_master_pkg`: state enum `scan_state_t` and a localparam for the minimum `PHASE_CYC`.
- Sub-module `scan_phase_timer`: counts `PHASE_CYC` cycles and issues a `phase_done` pulse on the last cycle of each *_HI/*_GAP state. It restarts on every state change.
- Top module contains the FSM, shift register, bit counter, synchronizer and output registers.

## Test plan
All scenarios use `CHAIN_LEN=8` and `PHASE_CYC=2`, with a behavioural `ex_scan` model (shift on `scan_phi_bar`, chip latch, capture mux).
- Write 0xA5, update=1, capture=0 → D=68, model chip register = 0xA5, `rsp_valid` at T+69, phases never overlap (assertion).
- Chip state 0x3C, capture=1, update=0, wdata=0x00 → `rsp_data`=0x3C, D=68, chip register unchanged.
- Capture+update, chip 0x81, wdata 0x7E → `rsp_data`=0x81, chip=0x7E, D=72.
- `reset` asserted in PHB_HI of bit 3 → next cycle all strobes 0, no `rsp_valid`. A new write of 0x55 then completes correctly.
- `cmd_valid` held high through a command → exactly one accept per IDLE. A second command is accepted at T+D+2 with a fresh `rsp_data`.
- `scan_data_out` toggled outside PHI_GAP sample windows → `rsp_data` unaffected.

Source files
------------

// File: rtl/scan_master_pkg.sv
// scan_master_pkg: shared state encoding and limits for the scan chain initiator.
package scan_master_pkg;

    // Shortest phase pulse/gap that still leaves the chip's latches non-overlapping.
    localparam int MIN_PHASE_CYC = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CAP_HI,
        S_CAP_GAP,
        S_PHI_HI,
        S_PHI_GAP,
        S_PHB_HI,
        S_PHB_GAP,
        S_UPD_HI,
        S_UPD_GAP,
        S_DONE
    } scan_state_t;

    // True for every state whose length is set by the phase timer.
    function automatic logic is_timed(input scan_state_t s);
        return !((s == S_IDLE) || (s == S_DONE));
    endfunction

endpackage

// File: rtl/scan_master_phase_timer.sv
// scan_phase_timer: measures PHASE_CYC cycles for each *_HI/*_GAP state and
// flags the last cycle. Because every timed state ends on that flag, clearing
// the count on it restarts the timer on each state change.
module scan_phase_timer #(
    parameter int PHASE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_phase_done
);

    localparam int CW = $clog2(PHASE_CYC);

    logic [CW-1:0] r_count;

    assign o_phase_done = i_run && (r_count == CW'(PHASE_CYC - 1));

    // Count cycles spent in the current timed state; idle states hold the count at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_run || o_phase_done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/scan_master.sv
// scan_master: turns a parallel write/read command into the two-phase,
// non-overlapping scan sequence of the ex_scan chain and returns the bits
// shifted out of the chip.
module scan_master
    import scan_master_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int PHASE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_capture,
    input  logic                 cmd_update,
    input  logic [CHAIN_LEN-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 scan_reset,
    output logic                 scan_phi,
    output logic                 scan_phi_bar,
    output logic                 scan_load_chip,
    output logic                 scan_load_chain,
    output logic                 scan_data_in,
    input  logic                 scan_data_out
);

    localparam int BW = $clog2(CHAIN_LEN);

    generate
        if (PHASE_CYC < MIN_PHASE_CYC) begin : g_bad_phase
            $error("scan_master: PHASE_CYC must be at least %0d", MIN_PHASE_CYC);
        end
        if (CHAIN_LEN < 2) begin : g_bad_len
            $error("scan_master: CHAIN_LEN must be at least 2");
        end
    endgenerate

    scan_state_t          r_state;
    scan_state_t          w_next;
    logic                 r_cap;
    logic                 r_upd;
    logic [BW-1:0]        r_bit;
    logic [CHAIN_LEN-1:0] r_sr;
    logic [CHAIN_LEN-1:0] w_sr_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sample;
    logic                 r_scan_reset;
    logic                 r_phi;
    logic                 r_phb;
    logic                 r_ld_chip;
    logic                 r_ld_chain;
    logic                 r_din;
    logic                 r_rsp_valid;
    logic [CHAIN_LEN-1:0] r_rsp_data;
    logic                 w_phase_done;
    logic                 w_accept;
    logic                 w_shift;

    assign cmd_ready       = (r_state == S_IDLE) && !reset;
    assign w_accept        = cmd_valid && cmd_ready;
    assign w_shift         = (r_state == S_PHB_GAP) && w_phase_done;

    assign scan_reset      = r_scan_reset;
    assign scan_phi        = r_phi;
    assign scan_phi_bar    = r_phb;
    assign scan_load_chip  = r_ld_chip;
    assign scan_load_chain = r_ld_chain;
    assign scan_data_in    = r_din;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_data        = r_rsp_data;

    scan_phase_timer #(
        .PHASE_CYC(PHASE_CYC)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_run       (is_timed(r_state)),
        .o_phase_done(w_phase_done)
    );

    // Forward the board reset to the chip one cycle later.
    always_ff @(posedge clk) begin
        r_scan_reset <= reset;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing: optional capture, phi/phi_bar pair per bit, optional update.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = cmd_capture ? S_CAP_HI : S_PHI_HI;
            S_CAP_HI:  if (w_phase_done) w_next = S_CAP_GAP;
            S_CAP_GAP: if (w_phase_done) w_next = S_PHI_HI;
            S_PHI_HI:  if (w_phase_done) w_next = S_PHI_GAP;
            S_PHI_GAP: if (w_phase_done) w_next = S_PHB_HI;
            S_PHB_HI:  if (w_phase_done) w_next = S_PHB_GAP;
            S_PHB_GAP: begin
                if (w_phase_done) begin
                    if (r_bit == '0) begin
                        w_next = r_upd ? S_UPD_HI : S_DONE;
                    end else begin
                        w_next = S_PHI_HI;
                    end
                end
            end
            S_UPD_HI:  if (w_phase_done) w_next = S_UPD_GAP;
            S_UPD_GAP: if (w_phase_done) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Shift register next value: load on accept, shift in the sampled bit at the end of each bit.
    always_comb begin
        w_sr_next = r_sr;
        if (w_accept) begin
            w_sr_next = cmd_wdata;
        end else if (w_shift) begin
            w_sr_next = {r_sr[CHAIN_LEN-2:0], r_sample};
        end
    end

    // Command latches, bit counter, shift register and the synchronized return bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap    <= 1'b0;
            r_upd    <= 1'b0;
            r_bit    <= '0;
            r_sr     <= '0;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sample <= 1'b0;
        end else begin
            r_sync1 <= scan_data_out;
            r_sync2 <= r_sync1;
            r_sr    <= w_sr_next;
            if (w_accept) begin
                r_cap <= cmd_capture;
                r_upd <= cmd_update;
                r_bit <= BW'(CHAIN_LEN - 1);
            end else if (w_shift && (r_bit != '0)) begin
                r_bit <= r_bit - BW'(1);
            end
            if ((r_state == S_PHI_GAP) && w_phase_done) begin
                r_sample <= r_sync2;
            end
        end
    end

    // Registered strobes and response, decoded from the state being entered so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phi       <= 1'b0;
            r_phb       <= 1'b0;
            r_ld_chip   <= 1'b0;
            r_ld_chain  <= 1'b0;
            r_din       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_phi       <= (w_next == S_PHI_HI);
            r_phb       <= (w_next == S_PHB_HI) || (w_next == S_CAP_HI);
            r_ld_chip   <= (w_next == S_UPD_HI);
            r_ld_chain  <= (w_next == S_CAP_HI);
            r_din       <= (w_next inside {S_PHI_HI, S_PHI_GAP, S_PHB_HI, S_PHB_GAP})
                           ? w_sr_next[CHAIN_LEN-1] : 1'b0;
            r_rsp_valid <= (w_next == S_DONE);
            if (w_next == S_DONE) begin
                r_rsp_data <= w_sr_next;
            end
        end
    end

endmodule
